// File: rtl/insn_queue_pkg.sv
// Shared constants and the storage element type for the fetch/decode instruction queue.
package insn_queue_pkg;

  localparam int unsigned FQ_AWIDTH = 32;
  localparam int unsigned FQ_DWIDTH = 32;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic [FQ_AWIDTH-1:0] pc;
    logic [FQ_DWIDTH-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/insn_queue_mem.sv
// DEPTH-entry register array for the instruction queue: one synchronous write
// port, one asynchronous read port. Contents are not reset.
module insn_queue_mem
  import insn_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  fq_entry_t       i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output fq_entry_t       o_rdata
);

  fq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/insn_queue.sv
// Instruction queue between fetch and decode: circular buffer with valid/ready
// on both sides and a redirect flush. Optional macro INSN_QUEUE_BYPASS_EN adds
// a 0-cycle path from fetch to decode when the queue is empty.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter  int DWIDTH = FQ_DWIDTH,
  parameter  int AWIDTH = FQ_AWIDTH,
  parameter  int DEPTH  = 4,
  localparam int CNTW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid_i,
  input  logic [AWIDTH-1:0] f_pc_i,
  input  logic [DWIDTH-1:0] f_insn_i,
  output logic              f_ready_o,
  output logic              d_valid_o,
  output logic [AWIDTH-1:0] d_pc_o,
  output logic [DWIDTH-1:0] d_insn_o,
  input  logic              d_ready_i,
  input  logic              flush_i,
  output logic [CNTW-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid on the same side.
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  logic      w_empty;
  logic      w_full;
  logic      w_push;
  logic      w_pop;
  logic      w_we;
  logic      w_byp;
  fq_entry_t w_wr_entry;
  fq_entry_t w_rd_entry;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNTW'(DEPTH));
  assign f_ready_o = ~w_full;
  assign w_push    = f_valid_i & f_ready_o;
  assign w_pop     = ~w_empty & d_ready_i;

`ifdef INSN_QUEUE_BYPASS_EN
  assign w_byp     = w_empty & f_valid_i & ~flush_i;
  assign d_valid_o = ~w_empty | w_byp;
  // A bypassed entry taken by decode in the same cycle is never stored.
  assign w_we      = w_push & ~flush_i & ~(w_byp & d_ready_i);
`else
  assign w_byp     = 1'b0;
  assign d_valid_o = ~w_empty;
  assign w_we      = w_push & ~flush_i;
`endif

  assign w_wr_entry = '{pc: f_pc_i, insn: f_insn_i};

  insn_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  always_comb begin
    d_pc_o   = '0;
    d_insn_o = DWIDTH'(NOP_INSN);
    if (w_byp) begin
      d_pc_o   = f_pc_i;
      d_insn_o = f_insn_i;
    end else if (~w_empty) begin
      d_pc_o   = w_rd_entry.pc;
      d_insn_o = w_rd_entry.insn;
    end
  end

  // Flush keeps wr_ptr and snaps rd_ptr onto it, discarding everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_we)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_we && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (!w_we && w_pop) r_count <= r_count - CNTW'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: tb/tb_insn_queue.sv
// Bench for insn_queue: directed scenarios plus a random run, all checked
// against a queue-based reference model.
module tb_insn_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_valid_i = 1'b0;
  logic [AW-1:0] f_pc_i = '0;
  logic [DW-1:0] f_insn_i = '0;
  logic          f_ready_o;
  logic          d_valid_o;
  logic [AW-1:0] d_pc_o;
  logic [DW-1:0] d_insn_o;
  logic          d_ready_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {pc, insn} of entries held by the queue, head at index 0.
  logic [AW+DW-1:0] exp_q[$];

  insn_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_valid_i (f_valid_i),
    .f_pc_i    (f_pc_i),
    .f_insn_i  (f_insn_i),
    .f_ready_o (f_ready_o),
    .d_valid_o (d_valid_o),
    .d_pc_o    (d_pc_o),
    .d_insn_o  (d_insn_o),
    .d_ready_i (d_ready_i),
    .flush_i   (flush_i),
    .count_o   (count_o)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_bypass();
`ifdef INSN_QUEUE_BYPASS_EN
    return (exp_q.size() == 0) && f_valid_i && !flush_i;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_valid();
    return (exp_q.size() != 0) || m_bypass();
  endfunction

  function automatic logic m_ready();
    return exp_q.size() != DEPTH;
  endfunction

  function automatic logic [AW-1:0] m_pc();
    if (m_bypass()) return f_pc_i;
    if (exp_q.size() != 0) return exp_q[0][AW+DW-1:DW];
    return '0;
  endfunction

  function automatic logic [DW-1:0] m_insn();
    if (m_bypass()) return f_insn_i;
    if (exp_q.size() != 0) return exp_q[0][DW-1:0];
    return NOP;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fv, input logic [AW-1:0] pc,
                       input logic dr, input logic fl);
    f_valid_i = fv;
    f_pc_i    = pc;
    f_insn_i  = {pc[15:0], 16'h0a5b} ^ 32'h5a5a0000;
    d_ready_i = dr;
    flush_i   = fl;
    #1;
  endtask

  // Advance one edge, applying the same transfer rules to the scoreboard.
  task automatic tick();
    bit pop_hs, push_hs, byp;
    pop_hs  = m_valid() && d_ready_i;
    push_hs = f_valid_i && m_ready();
    byp     = m_bypass();
    if (flush_i) exp_q.delete();
    else if (!(byp && d_ready_i)) begin
      if (pop_hs)  void'(exp_q.pop_front());
      if (push_hs) exp_q.push_back({f_pc_i, f_insn_i});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", d_valid_o); end
    total++; if (f_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", f_ready_o); end
    total++; if (d_insn_o !== NOP) begin bad++; $display("FAIL reset_insn got=%h exp=%h", d_insn_o, NOP); end
    total++; if (d_pc_o !== '0) begin bad++; $display("FAIL reset_pc got=%h exp=0", d_pc_o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h01000000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      total++; if (count_o !== CW'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count_o, i + 1); end
    end
    total++; if (f_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", f_ready_o); end
    drive(1'b1, 32'h01000010, 1'b0, 1'b0);
    tick();
    total++; if (count_o !== CW'(DEPTH)) begin bad++; $display("FAIL fill_extra_count got=%0d exp=%0d", count_o, DEPTH); end
    total++; if (d_pc_o !== 32'h01000000) begin bad++; $display("FAIL fill_head got=%h exp=01000000", d_pc_o); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      total++; if (d_pc_o !== 32'h01000000 + 32'(4 * i)) begin bad++; $display("FAIL drain_pc got=%h exp=%h", d_pc_o, 32'h01000000 + 32'(4 * i)); end
      total++; if (d_insn_o !== m_insn()) begin bad++; $display("FAIL drain_insn got=%h exp=%h", d_insn_o, m_insn()); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", d_valid_o); end
    total++; if (d_insn_o !== NOP) begin bad++; $display("FAIL drain_nop got=%h exp=%h", d_insn_o, NOP); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] nxt;
    nxt = 32'h01000100;
    drive(1'b1, 32'h010000fc, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, nxt, 1'b1, 1'b0);
      total++; if (d_pc_o !== nxt - 32'd4) begin bad++; $display("FAIL stream_pc got=%h exp=%h", d_pc_o, nxt - 32'd4); end
      tick();
      total++; if (count_o !== CW'(1)) begin bad++; $display("FAIL stream_count got=%0d exp=1", count_o); end
      nxt = nxt + 32'd4;
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h01000200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    total++; if (count_o !== CW'(3)) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
    drive(1'b1, 32'h01000040, 1'b1, 1'b1);
    total++; if (f_ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", f_ready_o); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (count_o !== '0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", d_valid_o); end
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 32'h01000300 + 32'(4 * i), i >= 2, 1'b0);
      total++; if (d_valid_o && d_pc_o === 32'h01000040) begin bad++; $display("FAIL flush_leak got=%h exp=not 01000040", d_pc_o); end
      total++; if (d_pc_o !== m_pc()) begin bad++; $display("FAIL flush_after_pc got=%h exp=%h", d_pc_o, m_pc()); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h01000400 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    total++; if (count_o !== CW'(2)) begin bad++; $display("FAIL areset_pre got=%0d exp=2", count_o); end
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    total++; if (count_o !== '0) begin bad++; $display("FAIL areset_count got=%0d exp=0", count_o); end
    total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", d_valid_o); end
    total++; if (f_ready_o !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", f_ready_o); end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h01000010, 1'b1, 1'b0);
`ifdef INSN_QUEUE_BYPASS_EN
    total++; if (d_valid_o !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b exp=1", d_valid_o); end
    total++; if (d_pc_o !== 32'h01000010) begin bad++; $display("FAIL byp_pc got=%h exp=01000010", d_pc_o); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (count_o !== '0) begin bad++; $display("FAIL byp_count got=%0d exp=0", count_o); end
`else
    total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL nobyp_valid got=%b exp=0", d_valid_o); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    total++; if (count_o !== CW'(1)) begin bad++; $display("FAIL nobyp_count got=%0d exp=1", count_o); end
    total++; if (d_pc_o !== 32'h01000010) begin bad++; $display("FAIL nobyp_pc got=%h exp=01000010", d_pc_o); end
    tick();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      total++; if (d_valid_o !== m_valid()) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, d_valid_o, m_valid()); end
      total++; if (f_ready_o !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, f_ready_o, m_ready()); end
      total++; if (d_pc_o !== m_pc()) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, d_pc_o, m_pc()); end
      total++; if (d_insn_o !== m_insn()) begin bad++; $display("FAIL rnd_insn cyc=%0d got=%h exp=%h", i, d_insn_o, m_insn()); end
      total++; if (count_o !== CW'(exp_q.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count_o, exp_q.size()); end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    // stream leaves one entry queued; flush test builds on it to reach 3
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
